// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - MIPS system-control coprocessor: SR/Cause/EPC/PRId, interrupt and exception request logic
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h4D495053
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] EPCOut
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:2] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] victim_pc;

    // Din bits outside the writable fields and the low PC bits are never stored.
    logic unused_bits;
    assign unused_bits = ^{Din[31:16], Din[9:2], victim_pc[1:0]};

    assign int_req   = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_req   = (ExcCodeIn != 5'd0) & ~exl_q;
    assign Req       = ~reset & (int_req | exc_req);
    assign victim_pc = BDIn ? (VPC - 32'd4) : VPC;
    assign EPCOut    = {epc_q, 2'b00};

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        ip_d       = HWInt;
        if (Req) begin
            // Taking the request discards any same-cycle mtc0 and eret.
            exl_d      = 1'b1;
            bd_d       = BDIn;
            exc_code_d = int_req ? 5'd0 : ExcCodeIn;
            epc_d      = victim_pc[31:2];
        end else begin
            if (WE) begin
                case (A)
                    REG_SR: begin
                        im_d  = Din[15:10];
                        exl_d = Din[1];
                        ie_d  = Din[0];
                    end
                    REG_EPC: epc_d = Din[31:2];
                    default: ;
                endcase
            end
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= 6'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= 6'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 30'd0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (A)
            REG_SR:    Dout = {16'd0, im_q, 8'd0, exl_q, ie_q};
            REG_CAUSE: Dout = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'b00};
            REG_EPC:   Dout = {epc_q, 2'b00};
            REG_PRID:  Dout = PRID;
            default:   Dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - scoreboard bench for cp0_unit with directed vectors
module tb_cp0_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  A;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        Req;
    logic [31:0] EPCOut;

    cp0_unit dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .WE        (WE),
        .Din       (Din),
        .Dout      (Dout),
        .VPC       (VPC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .Req       (Req),
        .EPCOut    (EPCOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int SEL_DOUT = 0;
    localparam int SEL_REQ  = 1;
    localparam int SEL_EPC  = 2;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: outputs are settled mid-cycle, so compare everything queued this cycle.
    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] got;
        while (sb_q.size() > 0) begin
            c = sb_q.pop_front();
            case (c.sel)
                SEL_DOUT: got = Dout;
                SEL_REQ:  got = {31'd0, Req};
                default:  got = EPCOut;
            endcase
            checks++;
            if (got !== c.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", c.name, got, c.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        sb_q.push_back(c);
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
        A = a;
        expect_val(name, SEL_DOUT, exp);
        step();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        A   = a;
        Din = d;
        WE  = 1'b1;
        step();
        WE  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; A = 5'd0; WE = 1'b0; Din = 32'd0; VPC = 32'd0;
        BDIn = 1'b0; ExcCodeIn = 5'd4; HWInt = 6'd0; EXLClr = 1'b0;
        step();
        step();
        expect_val("req_in_reset", SEL_REQ, 32'd0);
        step();
        reset = 1'b0;
        ExcCodeIn = 5'd0;
        rd(5'd12, 32'd0, "rst_sr");
        rd(5'd13, 32'd0, "rst_cause");
        rd(5'd14, 32'd0, "rst_epc");
        rd(5'd15, 32'h4D495053, "prid");
        rd(5'd3,  32'd0, "unmapped");

        // Timer interrupt
        mtc0(5'd12, 32'h0000_0401);
        HWInt = 6'b000001; VPC = 32'h0000_3010; BDIn = 1'b0;
        expect_val("int_req", SEL_REQ, 32'd1);
        step();
        expect_val("int_masked_exl", SEL_REQ, 32'd0);
        expect_val("int_epcout", SEL_EPC, 32'h0000_3010);
        rd(5'd14, 32'h0000_3010, "int_epc");
        rd(5'd13, 32'h0000_0400, "int_cause");
        rd(5'd12, 32'h0000_0403, "int_sr");

        // Exception in delay slot
        HWInt = 6'd0;
        mtc0(5'd12, 32'h0000_0001);
        ExcCodeIn = 5'd10; VPC = 32'h0000_3020; BDIn = 1'b1;
        expect_val("exc_req", SEL_REQ, 32'd1);
        step();
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        rd(5'd14, 32'h0000_301C, "exc_epc_bd");
        rd(5'd13, 32'h8000_0028, "exc_cause_bd");

        // EXL masks exceptions
        ExcCodeIn = 5'd4;
        expect_val("exc_masked_exl", SEL_REQ, 32'd0);
        step();
        ExcCodeIn = 5'd0;

        // Interrupt beats exception; concurrent mtc0 discarded
        mtc0(5'd12, 32'h0000_0401);
        HWInt = 6'b000001; ExcCodeIn = 5'd12; VPC = 32'h0000_4000; BDIn = 1'b0;
        A = 5'd14; Din = 32'h0000_1234; WE = 1'b1;
        expect_val("prio_req", SEL_REQ, 32'd1);
        step();
        WE = 1'b0; ExcCodeIn = 5'd0;
        rd(5'd14, 32'h0000_4000, "prio_epc_no_write");
        rd(5'd13, 32'h0000_0400, "prio_exccode0");

        // eret with level IRQ still asserted re-requests
        EXLClr = 1'b1;
        expect_val("eret_cycle_req", SEL_REQ, 32'd0);
        step();
        EXLClr = 1'b0;
        expect_val("rereq_after_eret", SEL_REQ, 32'd1);
        rd(5'd12, 32'h0000_0401, "eret_sr");
        HWInt = 6'd0;

        // EXLClr wins over mtc0 EXL bit, other SR fields written
        A = 5'd12; Din = 32'h0000_0803; WE = 1'b1; EXLClr = 1'b1;
        step();
        WE = 1'b0; EXLClr = 1'b0;
        rd(5'd12, 32'h0000_0801, "exlclr_vs_mtc0");

        // EPC write alignment
        mtc0(5'd14, 32'h0000_3007);
        expect_val("epcout_write", SEL_EPC, 32'h0000_3004);
        rd(5'd14, 32'h0000_3004, "epc_write");

        // Wrap-around of VPC-4
        ExcCodeIn = 5'd8; VPC = 32'd0; BDIn = 1'b1;
        expect_val("wrap_req", SEL_REQ, 32'd1);
        step();
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        expect_val("wrap_epcout", SEL_EPC, 32'hFFFF_FFFC);
        rd(5'd13, 32'h8000_0020, "wrap_cause");

        // Read-only registers
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, 32'h8000_0020, "cause_ro");
        mtc0(5'd15, 32'h0000_0000);
        rd(5'd15, 32'h4D495053, "prid_ro");

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
